move_stack_ctrl: RTL and testbench

//  Round-robin controller that shares one move stack (W-bit moves, DEPTH entries) among N ant agents.
//  It sequences each push or pop into single-cycle strobes on the stack, and tracks occupancy itself.
//  Ops that would overflow or underflow are refused with an error response; the stack is never touched.

---
 rtl/move_stack_ctrl.sv | 178 +++++++++++++++++
 tb/tb_move_stack_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_stack_ctrl.sv
// rtl/move_stack_ctrl.sv - round-robin arbiter sequencing N agents' push/pop ops onto one shared move stack
// Optional feature macro: MOVE_REVERSE_EN (popped move returned with its MSB flipped).
module move_stack_ctrl #(
  parameter int N     = 4,
  parameter int W     = 3,
  parameter int DEPTH = 32,
  localparam int IW   = $clog2(N),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_op,
  input  logic [N*W-1:0] req_move,
  input  logic           flush,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_move,
  output logic           rsp_err,
  output logic           stk_push,
  output logic           stk_pop,
  output logic           stk_clear,
  output logic [W-1:0]   stk_wdata,
  input  logic [W-1:0]   stk_rdata,
  output logic [CW-1:0]  depth,
  output logic           full,
  output logic           empty
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] id_q, id_d;
  logic          op_q, op_d;
  logic [W-1:0]  move_q, move_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [W-1:0]  rmove_q, rmove_d;

  logic [IW-1:0] pick;
  logic          any_req;
  logic [IW-1:0] id_next;
  logic [W-1:0]  pop_val;

`ifdef MOVE_REVERSE_EN
  localparam logic [W-1:0] REV_MASK = W'(1) << (W - 1);
  assign pop_val = stk_rdata ^ REV_MASK;
`else
  assign pop_val = stk_rdata;
`endif

  assign depth = depth_q;
  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);

  assign id_next = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);

  // Scan downward so the candidate closest to rr_q overwrites the others.
  always_comb begin
    logic [IW-1:0] cand;
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_q) + k) % N);
      if (req[cand]) begin
        pick    = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    op_d      = op_q;
    move_d    = move_q;
    depth_d   = depth_q;
    err_d     = err_q;
    rmove_d   = rmove_q;
    gnt       = '0;
    rsp_valid = 1'b0;
    rsp_id    = '0;
    rsp_move  = '0;
    rsp_err   = 1'b0;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = flush;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d    = pick;
          op_d    = req_op[pick];
          move_d  = req_move[pick*W +: W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt     = N'(1) << id_q;
        rr_d    = id_next;
        err_d   = 1'b0;
        rmove_d = '0;
        state_d = S_RESP;
        if (op_q == OP_PUSH) begin
          if (!full) begin
            stk_push = 1'b1;
            depth_d  = depth_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (!empty) begin
            stk_pop = 1'b1;
            rmove_d = pop_val;
            depth_d = depth_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_move  = rmove_q;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything; a granted op is dropped without touching the stack.
    if (flush) begin
      state_d   = S_IDLE;
      depth_d   = '0;
      stk_push  = 1'b0;
      stk_pop   = 1'b0;
      rsp_valid = 1'b0;
      rsp_id    = '0;
      rsp_move  = '0;
      rsp_err   = 1'b0;
    end
  end

  assign stk_wdata = stk_push ? move_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= 1'b0;
      move_q  <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
      rmove_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      move_q  <= move_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      rmove_q <= rmove_d;
    end
  end

endmodule

// File: tb/tb_move_stack_ctrl.sv
// tb/tb_move_stack_ctrl.sv - self-checking bench for move_stack_ctrl: vector table, directed corners, random vs model
module tb_move_stack_ctrl;

  localparam int N     = 4;
  localparam int W     = 3;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_move;
  logic           flush;
  logic [N-1:0]   gnt;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_move;
  logic           rsp_err;
  logic           stk_push;
  logic           stk_pop;
  logic           stk_clear;
  logic [W-1:0]   stk_wdata;
  logic [W-1:0]   stk_rdata;
  logic [5:0]     depth;
  logic           full;
  logic           empty;

  int errors = 0;
  int checks = 0;

  move_stack_ctrl #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_move(req_move),
    .flush(flush), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_move(rsp_move), .rsp_err(rsp_err), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_clear(stk_clear), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
    .depth(depth), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment stack storage, driven only by the controller's strobes.
  logic [W-1:0] mem [0:63];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= 0;
    else if (stk_clear) sp <= 0;
    else if (stk_push && sp < 64) begin
      mem[sp] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end
  assign stk_rdata = (sp > 0) ? mem[sp-1] : '0;

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
`ifdef MOVE_REVERSE_EN
    return v ^ 3'b100;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_op = '0; req_move = '0; flush = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one op from agent id starting at a negedge; returns when its response is seen.
  task automatic do_op(input int id, input logic op, input logic [W-1:0] mv,
                       output logic err, output logic [W-1:0] mo,
                       output logic saw_push, output logic saw_pop);
    bit done;
    done = 0; err = 0; mo = 0; saw_push = 0; saw_pop = 0;
    req[id] = 1'b1; req_op[id] = op; req_move[id*W +: W] = mv;
    for (int t = 0; t < 12 && !done; t++) begin
      step();
      #1;
      if (gnt[id]) begin
        saw_push = stk_push;
        saw_pop  = stk_pop;
        req[id]  = 1'b0;
      end
      if (rsp_valid) begin
        err = rsp_err;
        mo  = rsp_move;
        done = 1;
      end
    end
    if (!done) begin
      chk("op_timeout", 32'd0, 32'd1);
      req[id] = 1'b0;
    end
  endtask

  typedef struct {
    logic [N-1:0]   rq;
    logic [N-1:0]   op;
    logic [N*W-1:0] mv;
    logic [N-1:0]   e_gnt;
    logic           e_push;
    logic [W-1:0]   e_wdata;
    logic           e_rv;
    logic [1:0]     e_rid;
    logic [5:0]     e_depth;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(input logic [3:0] g, input logic p, input logic [2:0] wd,
                              input logic rv, input logic [1:0] rid, input logic [5:0] d);
    vec_t v;
    v.rq = 4'b1111; v.op = 4'b0000;
    v.mv = {3'd4, 3'd3, 3'd2, 3'd5};
    v.e_gnt = g; v.e_push = p; v.e_wdata = wd; v.e_rv = rv; v.e_rid = rid; v.e_depth = d;
    return v;
  endfunction

  // Reference model state
  int mq[$];
  int ph, cid, rr;
  logic cop;
  logic [W-1:0] cmv, mmove;
  logic merr;
  bit pend[N];

  initial begin
    logic e; logic [W-1:0] m; logic sp_push, sp_pop;

    vt[0]  = mk(4'b0000, 0, 0, 0, 0, 0);
    vt[1]  = mk(4'b0001, 1, 5, 0, 0, 0);
    vt[2]  = mk(4'b0000, 0, 0, 1, 0, 1);
    vt[3]  = mk(4'b0000, 0, 0, 0, 0, 1);
    vt[4]  = mk(4'b0010, 1, 2, 0, 0, 1);
    vt[5]  = mk(4'b0000, 0, 0, 1, 1, 2);
    vt[6]  = mk(4'b0000, 0, 0, 0, 0, 2);
    vt[7]  = mk(4'b0100, 1, 3, 0, 0, 2);
    vt[8]  = mk(4'b0000, 0, 0, 1, 2, 3);
    vt[9]  = mk(4'b0000, 0, 0, 0, 0, 3);
    vt[10] = mk(4'b1000, 1, 4, 0, 0, 3);
    vt[11] = mk(4'b0000, 0, 0, 1, 3, 4);
    vt[12] = mk(4'b0000, 0, 0, 0, 0, 4);
    vt[13] = mk(4'b0001, 1, 5, 0, 0, 4);
    vt[14] = mk(4'b0000, 0, 0, 1, 0, 5);

    rst_n = 1'b0;
    req = '0; req_op = '0; req_move = '0; flush = 1'b0;
    #3;
    chk("reset_gnt", gnt, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_strobes", {stk_push, stk_pop, stk_clear}, 0);
    chk("reset_depth", depth, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    do_reset();

    // Vector table: all four agents pushing from reset
    for (int k = 0; k < 15; k++) begin
      req = vt[k].rq; req_op = vt[k].op; req_move = vt[k].mv;
      #1;
      chk($sformatf("vec%0d_gnt", k), gnt, vt[k].e_gnt);
      chk($sformatf("vec%0d_push", k), stk_push, vt[k].e_push);
      chk($sformatf("vec%0d_wdata", k), stk_wdata, vt[k].e_wdata);
      chk($sformatf("vec%0d_rsp_valid", k), rsp_valid, vt[k].e_rv);
      chk($sformatf("vec%0d_rsp_id", k), rsp_id, vt[k].e_rid);
      chk($sformatf("vec%0d_rsp_err", k), rsp_err, 0);
      chk($sformatf("vec%0d_depth", k), depth, vt[k].e_depth);
      step();
    end

    // Overflow refusal
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_op(i % N, 1'b0, W'(i), e, m, sp_push, sp_pop);
      if (i == DEPTH - 1) chk("fill_last_err", e, 0);
    end
    step(); #1;
    chk("fill_depth", depth, DEPTH);
    chk("fill_full", full, 1);
    do_op(1, 1'b0, 3'd6, e, m, sp_push, sp_pop);
    chk("ovf_err", e, 1);
    chk("ovf_no_push", sp_push, 0);
    step(); #1;
    chk("ovf_depth", depth, DEPTH);
    chk("ovf_full", full, 1);

    // Underflow refusal
    do_reset();
    do_op(2, 1'b1, 3'd7, e, m, sp_push, sp_pop);
    chk("unf_err", e, 1);
    chk("unf_move", m, 0);
    chk("unf_no_pop", sp_pop, 0);
    step(); #1;
    chk("unf_empty", empty, 1);

    // Push then pop returns the move
    do_reset();
    do_op(0, 1'b0, 3'd1, e, m, sp_push, sp_pop);
    chk("pp_push_strobe", sp_push, 1);
    chk("pp_push_move", m, 0);
    do_op(3, 1'b1, 3'd0, e, m, sp_push, sp_pop);
    chk("pp_pop_strobe", sp_pop, 1);
    chk("pp_pop_err", e, 0);
    chk("pp_pop_move", m, rev(3'd1));
    step(); #1;
    chk("pp_depth", depth, 0);

    // Flush during ISSUE of a pop
    do_reset();
    for (int i = 0; i < 10; i++) do_op(i % N, 1'b0, W'(i), e, m, sp_push, sp_pop);
    req[1] = 1'b1; req_op[1] = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 6 && !seen; t++) begin
        step(); #1;
        if (gnt[1]) seen = 1;
      end
      chk("flush_gnt_seen", seen, 1);
    end
    chk("flush_pre_depth", depth, 10);
    flush = 1'b1;
    #1;
    chk("flush_clear", stk_clear, 1);
    chk("flush_no_pop", stk_pop, 0);
    chk("flush_gnt_still", gnt, 4'b0010);
    req[1] = 1'b0;
    step();
    flush = 1'b0;
    #1;
    chk("flush_clear_pulse", stk_clear, 0);
    chk("flush_depth", depth, 0);
    chk("flush_empty", empty, 1);
    for (int t = 0; t < 3; t++) begin
      chk("flush_no_rsp", rsp_valid, 0);
      step(); #1;
    end

    // Random traffic against the reference model
    do_reset();
    mq = {}; ph = 0; rr = 0; cid = 0; cop = 0; cmv = 0; mmove = 0; merr = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [N-1:0] eg;
      logic ep, epo, erv;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          req_op[i] = ($urandom_range(0, 9) < 4);
          req_move[i*W +: W] = W'($urandom_range(0, 7));
        end
        req[i] = pend[i];
      end
      flush = ($urandom_range(0, 99) < 2);
      #1;
      eg  = (ph == 1) ? N'(1) << cid : '0;
      ep  = (ph == 1) && !cop && mq.size() < DEPTH && !flush;
      epo = (ph == 1) && cop && mq.size() > 0 && !flush;
      erv = (ph == 2) && !flush;
      chk("rnd_gnt", gnt, eg);
      chk("rnd_push", stk_push, ep);
      chk("rnd_pop", stk_pop, epo);
      chk("rnd_wdata", stk_wdata, ep ? cmv : '0);
      chk("rnd_clear", stk_clear, flush);
      chk("rnd_rsp_valid", rsp_valid, erv);
      chk("rnd_rsp", {rsp_id, rsp_move, rsp_err}, erv ? {2'(cid), mmove, merr} : '0);
      chk("rnd_depth", depth, mq.size());
      chk("rnd_flags", {full, empty}, {mq.size() == DEPTH, mq.size() == 0});
      if (flush) begin
        if (ph == 1) rr = (cid + 1) % N;
        mq = {};
        ph = 0;
      end else begin
        case (ph)
          0: begin
            for (int k = 0; k < N; k++) begin
              int c;
              c = (rr + k) % N;
              if (req[c]) begin
                cid = c; cop = req_op[c]; cmv = req_move[c*W +: W];
                ph = 1;
                break;
              end
            end
          end
          1: begin
            merr = 0; mmove = 0;
            if (!cop && mq.size() < DEPTH) mq.push_back(int'(cmv));
            else if (cop && mq.size() > 0) mmove = rev(W'(mq.pop_back()));
            else merr = 1;
            rr = (cid + 1) % N;
            ph = 2;
          end
          default: ph = 0;
        endcase
      end
      for (int i = 0; i < N; i++) if (gnt[i]) pend[i] = 0;
      step();
    end

    // Async reset in the middle of an op
    do_reset();
    req[0] = 1'b1; req_op[0] = 1'b0; req_move[2:0] = 3'd3;
    step(); #1;
    chk("arst_gnt_before", gnt, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", gnt, 0);
    chk("arst_push", stk_push, 0);
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("arst_quiet", {gnt, rsp_valid, stk_push}, 0);
      chk("arst_depth", depth, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
